// File: rtl/tbird_pkg.sv
// tbird_pkg: shared lamp constants, mode/state/error types and pattern helpers
package tbird_pkg;

   localparam logic [2:0] LAMP_OFF = 3'b000;
   localparam logic [2:0] LAMP_1   = 3'b001;
   localparam logic [2:0] LAMP_2   = 3'b011;
   localparam logic [2:0] LAMP_3   = 3'b111;

   typedef enum logic [1:0] {MODE_IDLE, MODE_LEFT, MODE_RIGHT, MODE_HAZ} tbird_mode_e;

   typedef enum logic [3:0] {
      ST_IDLE, ST_L1, ST_L2, ST_L3, ST_R1, ST_R2, ST_R3, ST_HAZ, ST_BAD
   } tbird_state_e;

   typedef enum logic [1:0] {ERR_NONE, ERR_BAD, ERR_SUCC, ERR_EARLY} tbird_err_e;

   function automatic tbird_state_e classify(input logic [2:0] l, input logic [2:0] r);
      case ({l, r})
         {LAMP_OFF, LAMP_OFF}: return ST_IDLE;
         {LAMP_1,   LAMP_OFF}: return ST_L1;
         {LAMP_2,   LAMP_OFF}: return ST_L2;
         {LAMP_3,   LAMP_OFF}: return ST_L3;
         {LAMP_OFF, LAMP_1  }: return ST_R1;
         {LAMP_OFF, LAMP_2  }: return ST_R2;
         {LAMP_OFF, LAMP_3  }: return ST_R3;
         {LAMP_3,   LAMP_3  }: return ST_HAZ;
         default:              return ST_BAD;
      endcase
   endfunction

   // hazard may pre-empt any side sequence; a lit hazard must blink back to idle
   function automatic logic legal_next(input tbird_state_e s, input tbird_state_e p);
      case (s)
         ST_IDLE: return p inside {ST_IDLE, ST_L1, ST_R1, ST_HAZ};
         ST_L1:   return p inside {ST_L2, ST_HAZ};
         ST_L2:   return p inside {ST_L3, ST_HAZ};
         ST_L3:   return p inside {ST_IDLE, ST_HAZ};
         ST_R1:   return p inside {ST_R2, ST_HAZ};
         ST_R2:   return p inside {ST_R3, ST_HAZ};
         ST_R3:   return p inside {ST_IDLE, ST_HAZ};
         ST_HAZ:  return p == ST_IDLE;
         default: return 1'b0;
      endcase
   endfunction

   function automatic tbird_mode_e to_mode(input tbird_state_e s);
      return s == ST_HAZ ? MODE_HAZ :
             s inside {ST_L1, ST_L2, ST_L3} ? MODE_LEFT :
             s inside {ST_R1, ST_R2, ST_R3} ? MODE_RIGHT : MODE_IDLE;
   endfunction

endpackage

// File: rtl/tbird_light_monitor_if.sv
// tbird_light_monitor_if: tail-light lamp bus from the light FSM (master) to observers (slave)
interface tbird_light_monitor_if;
   logic [2:0] l_lights;
   logic [2:0] r_lights;
   modport master (output l_lights, r_lights);
   modport slave  (input  l_lights, r_lights);
endinterface

// File: rtl/tbird_sat_cnt.sv
// tbird_sat_cnt: saturating event counter with synchronous clear that beats increment
module tbird_sat_cnt #(parameter int W = 8) (
   input  logic         clk,
   input  logic         rst_b,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] cnt
);
   logic [W-1:0] cnt_q;
   // count up, hold at all-ones, clear has priority
   always_ff @(posedge clk or negedge rst_b)
      if (!rst_b) cnt_q <= '0;
      else if (clr) cnt_q <= '0;
      else if (inc && !(&cnt_q)) cnt_q <= cnt_q + W'(1);
   assign cnt = cnt_q;
endmodule

// File: rtl/tbird_light_monitor.sv
// tbird_light_monitor: passive checker of Thunderbird tail-light patterns; optional TBIRD_MON_STICKY_ERR_EN adds err_sticky
module tbird_light_monitor
   import tbird_pkg::*;
#(parameter int CNT_W = 8) (
   input  logic                 clk,
   input  logic                 rst_b,
   tbird_light_monitor_if.slave lights,
   input  logic                 clr,
   output logic [1:0]           mode,
   output logic                 err,
   output logic [1:0]           err_code,
   output logic [CNT_W-1:0]     left_cnt,
   output logic [CNT_W-1:0]     right_cnt,
   output logic [CNT_W-1:0]     haz_cnt,
   output logic [CNT_W-1:0]     err_cnt
`ifdef TBIRD_MON_STICKY_ERR_EN
   ,output logic                err_sticky
`endif
);
   tbird_state_e state_q, state_d, p;
   tbird_err_e   code_q, code_d;
   logic         err_q, err_d;
   logic         left_inc, right_inc, haz_inc;

   // tracked pattern state and registered error report
   always_ff @(posedge clk or negedge rst_b)
      if (!rst_b) begin
         state_q <= ST_IDLE;
         err_q   <= 1'b0;
         code_q  <= ERR_NONE;
      end else begin
         state_q <= state_d;
         err_q   <= err_d;
         code_q  <= code_d;
      end

   // judge the sampled pattern against the tracked state; illegal successors resync to the sample
   always_comb begin
      p       = classify(lights.l_lights, lights.r_lights);
      state_d = p == ST_BAD ? ST_IDLE : p;
      code_d  = p == ST_BAD ? ERR_BAD :
                legal_next(state_q, p) ? ERR_NONE :
                p == ST_IDLE ? ERR_EARLY : ERR_SUCC;
      err_d   = code_d != ERR_NONE;
   end

   // decoded mode, error outputs and completed-cycle strobes
   always_comb begin
      mode      = to_mode(state_q);
      err       = err_q;
      err_code  = code_q;
      left_inc  = state_q == ST_L3  && p == ST_IDLE;
      right_inc = state_q == ST_R3  && p == ST_IDLE;
      haz_inc   = state_q == ST_HAZ && p == ST_IDLE;
   end

   tbird_sat_cnt #(.W(CNT_W)) u_left  (.clk(clk), .rst_b(rst_b), .inc(left_inc),  .clr(clr), .cnt(left_cnt));
   tbird_sat_cnt #(.W(CNT_W)) u_right (.clk(clk), .rst_b(rst_b), .inc(right_inc), .clr(clr), .cnt(right_cnt));
   tbird_sat_cnt #(.W(CNT_W)) u_haz   (.clk(clk), .rst_b(rst_b), .inc(haz_inc),   .clr(clr), .cnt(haz_cnt));
   tbird_sat_cnt #(.W(CNT_W)) u_err   (.clk(clk), .rst_b(rst_b), .inc(err_d),     .clr(clr), .cnt(err_cnt));

`ifdef TBIRD_MON_STICKY_ERR_EN
   logic sticky_q;
   // sticky error flag; a new error wins over a same-cycle clear
   always_ff @(posedge clk or negedge rst_b)
      if (!rst_b) sticky_q <= 1'b0;
      else sticky_q <= err_d | (sticky_q & ~clr);
   assign err_sticky = sticky_q;
`endif

endmodule

// File: doc/tbird_light_monitor.md
# tbird_light_monitor

Passive checker/decoder on the tail-light outputs of the Thunderbird turn-signal FSM. It samples `l_lights`/`r_lights` every clock and tracks the expected next pattern. It reports the decoded signalling mode, flags illegal or out-of-order patterns, and counts completed left, right and hazard cycles. It sits beside the light FSM in the top level and in benches as the consumer of its outputs; it drives nothing back.

## Interface
- `CNT_W`, 8, width of each event counter (≥2)
- `clk`  in  1  system clock, rising edge
- `rst_b`  in  1  reset; asynchronous, active-low
- `l_lights`  in  3  left lamps, bit0 innermost
- `r_lights`  in  3  right lamps, bit0 innermost
- `clr`  in  1  synchronous clear of counters (and sticky flag)
- `mode`  out  2  decoded mode: 0 IDLE, 1 LEFT, 2 RIGHT, 3 HAZ
- `err`  out  1  one-cycle error pulse
- `err_code`  out  2  0 none, 1 unclassifiable pattern, 2 wrong successor, 3 early termination; valid when `err`=1, else 0
- `left_cnt`, `right_cnt`, `haz_cnt`, `err_cnt`  out  CNT_W each  saturating event counters
- `err_sticky`  out  1  present only with `TBIRD_MON_STICKY_ERR_EN`

## Operation
- Pattern class P = {l,r}: {000,000}→IDLE; {001,000}→L1; {011,000}→L2; {111,000}→L3; {000,001}→R1; {000,011}→R2; {000,111}→R3; {111,111}→HAZ; anything else → BAD.
- States: IDLE, L1, L2, L3, R1, R2, R3, HAZ. Each lit state lasts exactly one cycle.
- Legal successors:
  - IDLE→IDLE | L1 | R1 | HAZ
  - L1→L2, L2→L3, L3→IDLE (left_cnt++)
  - R1→R2, R2→R3, R3→IDLE (right_cnt++)
  - HAZ→IDLE (haz_cnt++)
  - Any L/R state→HAZ is legal hazard pre-emption; no count for the aborted side.
- Errors, each causing err=1 and err_cnt++:
  - P=BAD: code 1; next state IDLE.
  - P=IDLE from L1/L2/R1/R2: code 3; next state IDLE.
  - Any other illegal successor: code 2; resync, next state = class(P).
  - HAZ→HAZ is code 2 (hazard must blink).
- `mode`: IDLE→0; L1–L3→1; R1–R3→2; HAZ→3.
- Counters saturate at 2^CNT_W−1 and never wrap.
- `clr` zeroes all counters; `clr` beats a same-cycle increment.
- `clr` does not affect state, `mode` or `err`.

## Timing
- State, `mode`, `err`, `err_code` and counters are all registered. Each reflects the pattern sampled at the previous rising edge: 1-cycle latency.
- A counter increment is visible in the cycle after the edge that samples the closing pattern (000,000 after L3/R3/HAZ).
- Reset (async assert, sync-released by the system): state IDLE, `mode`=0, `err`=0, `err_code`=0, all counters 0, `err_sticky`=0.
- Reset mid-sequence returns to IDLE. The first post-reset sample is judged from IDLE, so e.g. l=011 gives code 2, resync L2.
- Persistent BAD input gives `err`=1 every cycle and err_cnt increments every cycle until it saturates.

## Configuration
- `TBIRD_MON_STICKY_ERR_EN` defined:
  - Adds the `err_sticky` output.
  - `err_sticky` is set on any `err` and held until `clr` or reset.
  - If `err` and `clr` occur in the same cycle, set wins.
- Undefined: no `err_sticky` port and no related logic; all other behaviour is identical.

## Structure
- Shared package `tbird_pkg` holds:
  - `tbird_mode_e` (2-bit)
  - `tbird_state_e`
  - `tbird_err_e` (2-bit)
  - `function classify(l,r)` returning state-or-BAD
  - lamp constants `LAMP_OFF=3'b000`, `LAMP_1=3'b001`, `LAMP_2=3'b011`, `LAMP_3=3'b111`
- One sub-module, `tbird_sat_cnt` (parameter W; inc, clr, cnt), instantiated four times.

## Test plan
- Reset then idle 5 cycles → `mode`=0, `err`=0, all counters 0.
- Left sequence 001,011,111,000 on `l_lights` (`r_lights`=000) → `mode` 1,1,1,0 one cycle late; `left_cnt`=1; no `err`. Repeat mirrored on right → `right_cnt`=1.
- Hazard: 111/111 then 000/000, three times → `mode` alternates 3/0; `haz_cnt`=3. Hazard after L1 → legal; `left_cnt` unchanged.
- Errors:
  - l=011 directly from IDLE → `err`=1, code 2, then `mode`=1 and sequence continues.
  - l=001, r=001 → code 1.
  - L1 then 000 → code 3.
  - `err_cnt`=3.
- CNT_W=2: seven left sequences → `left_cnt` holds 3. Then `clr` with a same-cycle completion → `left_cnt`=0.
- With `TBIRD_MON_STICKY_ERR_EN`: one error → `err_sticky` stays 1 through later legal traffic until `clr`. Error plus `clr` in the same cycle → stays 1.
